// File: rtl/cathetus.sv
`default_nettype none
// ============================================================================
// Module   : cathetus
// Purpose  : y = floor(sqrt(c*c - a*a)) using a shared shift-add multiplier and
//            a restoring bit-serial square root, with a start/busy handshake.
// Revision : 1.0
// ============================================================================
module cathetus (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] c,
    input  logic [7:0] a,
    output logic       busy,
    output logic       err,
    output logic [7:0] y
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQ_C = 2'd1,
        S_SQ_A = 2'd2,
        S_SQRT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [7:0]  r_c;
    logic [7:0]  r_a;
    logic [15:0] r_acc;
    logic [15:0] r_csq;
    logic [15:0] r_rad;
    logic [9:0]  r_rem;
    logic [7:0]  r_root;
    logic [7:0]  r_y;
    logic        r_err;

    logic        w_last;
    logic [7:0]  w_x;
    logic [15:0] w_add;
    logic [15:0] w_acc_nxt;
    logic [9:0]  w_rem_sh;
    logic [9:0]  w_trial;
    logic        w_fit;
    logic [9:0]  w_rem_nxt;
    logic [7:0]  w_root_nxt;

    assign w_last    = (r_cnt == 3'd7);

    // One multiplier bit per cycle, LSB first; operand selected by phase.
    assign w_x       = (r_state == S_SQ_A) ? r_a : r_c;
    assign w_add     = w_x[r_cnt] ? ({8'd0, w_x} << r_cnt) : 16'd0;
    assign w_acc_nxt = r_acc + w_add;

    // The 12-bit compare covers the full remainder; the kept difference
    // always fits in 10 bits, so the 10-bit subtraction is exact.
    assign w_rem_sh   = {r_rem[7:0], r_rad[15:14]};
    assign w_trial    = {r_root, 2'b01};
    assign w_fit      = ({r_rem, r_rad[15:14]} >= {2'b00, r_root, 2'b01});
    assign w_rem_nxt  = w_fit ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_nxt = {r_root[6:0], w_fit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start && (a <= c)) w_state_nxt = S_SQ_C;
            S_SQ_C:  if (w_last) w_state_nxt = S_SQ_A;
            S_SQ_A:  if (w_last) w_state_nxt = S_SQRT;
            S_SQRT:  if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 3'd0;
            r_c    <= 8'd0;
            r_a    <= 8'd0;
            r_acc  <= 16'd0;
            r_csq  <= 16'd0;
            r_rad  <= 16'd0;
            r_rem  <= 10'd0;
            r_root <= 8'd0;
            r_y    <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_c   <= c;
                        r_a   <= a;
                        r_y   <= 8'd0;
                        r_err <= (a > c);
                        r_cnt <= 3'd0;
                        r_acc <= 16'd0;
                    end
                end
                S_SQ_C: begin
                    r_cnt <= r_cnt + 3'd1;
                    r_acc <= w_acc_nxt;
                    if (w_last) begin
                        r_csq <= w_acc_nxt;
                        r_acc <= 16'd0;
                    end
                end
                S_SQ_A: begin
                    r_cnt <= r_cnt + 3'd1;
                    r_acc <= w_acc_nxt;
                    if (w_last) begin
                        r_rad  <= r_csq - w_acc_nxt;
                        r_rem  <= 10'd0;
                        r_root <= 8'd0;
                    end
                end
                S_SQRT: begin
                    r_cnt  <= r_cnt + 3'd1;
                    r_rem  <= w_rem_nxt;
                    r_root <= w_root_nxt;
                    r_rad  <= {r_rad[13:0], 2'b00};
                    if (w_last) r_y <= w_root_nxt;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign err  = r_err;
    assign y    = r_y;

endmodule
`default_nettype wire

// File: tb/tb_cathetus.sv
`default_nettype none
// ============================================================================
// Module   : tb_cathetus
// Purpose  : Directed and randomized checks of cathetus against an integer
//            square-root reference model.
// Revision : 1.0
// ============================================================================
module tb_cathetus;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] c;
    logic [7:0] a;
    logic       busy;
    logic       err;
    logic [7:0] y;

    int n_chk;
    int n_fail;

    cathetus dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .c     (c),
        .a     (a),
        .busy  (busy),
        .err   (err),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Largest r with r*r <= c*c - a*a.
    function automatic int ref_leg(input int cv, input int av);
        int v;
        int r;
        v = cv * cv - av * av;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with busy high, starting from the current sample point.
    task automatic wait_idle(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            n++;
            tick();
        end
    endtask

    // Issue one valid request; optionally pulse a spurious start at busy cycle poke.
    task automatic run(input string tag, input int cv, input int av, input int poke);
        int n;
        start = 1'b1; c = cv[7:0]; a = av[7:0];
        tick();
        start = 1'b0;
        check({tag, " busy_at_accept"}, busy, 1);
        check({tag, " y_cleared"}, y, 0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            n++;
            if (n == poke) begin
                start = 1'b1; c = 8'd99; a = 8'd1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, n, 24);
        check({tag, " y"}, y, ref_leg(cv, av));
        check({tag, " err"}, err, 0);
    endtask

    task automatic err_req(input string tag, input int cv, input int av);
        start = 1'b1; c = cv[7:0]; a = av[7:0];
        tick();
        start = 1'b0;
        check({tag, " err"}, err, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " y"}, y, 0);
        tick();
        check({tag, " busy_later"}, busy, 0);
    endtask

    initial begin
        int n;
        int cv;
        int av;
        n_chk = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; c = 8'd0; a = 8'd0;
        tick(); tick();
        rst = 1'b0;
        check("reset busy", busy, 0);
        check("reset err", err, 0);
        check("reset y", y, 0);

        run("c5a3", 5, 3, 10);
        check("c5a3 model", y, 4);
        run("c10a3", 10, 3, 0);
        check("c10a3 model", y, 9);
        run("c255a0", 255, 0, 0);
        check("c255a0 model", y, 255);
        run("c200a200", 200, 200, 0);
        run("c1a0", 1, 0, 0);
        check("c1a0 model", y, 1);

        err_req("c3a5", 3, 5);
        run("c13a5", 13, 5, 0);
        check("c13a5 model", y, 12);

        // Reset in the middle of a computation.
        start = 1'b1; c = 8'd100; a = 8'd60;
        tick();
        start = 1'b0;
        for (int k = 0; k < 11; k++) tick();
        check("midrst still_busy", busy, 1);
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst err", err, 0);
        check("midrst y", y, 0);
        run("c100a60", 100, 60, 0);
        check("c100a60 model", y, 80);

        // Back-to-back with start held high.
        start = 1'b1; c = 8'd17; a = 8'd8;
        tick();
        c = 8'd25; a = 8'd7;
        wait_idle(n);
        check("b2b first_busy", n, 24);
        check("b2b first_y", y, 15);
        tick();
        start = 1'b0;
        check("b2b second_accept", busy, 1);
        wait_idle(n);
        check("b2b second_busy", n, 24);
        check("b2b second_y", y, 24);

        for (int i = 0; i < 2000; i++) begin
            cv = int'($urandom_range(0, 255));
            av = int'($urandom_range(0, cv));
            run("rand", cv, av, 0);
        end
        for (int i = 0; i < 200; i++) begin
            cv = int'($urandom_range(0, 254));
            av = int'($urandom_range(cv + 1, 255));
            err_req("rand_err", cv, av);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
